// File: rtl/weather_tx_scheduler.sv
// Hour-gated, round-robin transmit scheduler for three sensor channels.
// Packs the granted reading into an even-parity 9-bit frame and sends it over valid/ready with timeout and guard gap.
module weather_tx_scheduler #(
  parameter int WIN_START  = 12,
  parameter int WIN_END    = 15,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] current_hour,
  input  logic [2:0] req,
  input  logic [5:0] temp_in,
  input  logic [5:0] hum_in,
  input  logic [4:0] wind_in,
  input  logic       frame_ready,
  output logic [2:0] grant,
  output logic [8:0] frame,
  output logic       frame_valid,
  output logic       enable_transceiver,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  localparam logic [4:0] L_WIN_START = 5'(WIN_START);
  localparam logic [4:0] L_WIN_END   = 5'(WIN_END);
  localparam logic [7:0] L_WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] L_GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [7:0] r_wait;
  logic [3:0] r_gap;

  logic       w_in_window;
  logic [1:0] w_o0, w_o1, w_o2;
  logic [1:0] w_sel;
  logic [1:0] w_ptr_next;
  logic [5:0] w_payload;
  logic [8:0] w_frame;

  // Hours 24..31 are never inside the window, whatever the parameters say.
  assign w_in_window = (current_hour >= L_WIN_START) && (current_hour <= L_WIN_END) &&
                       (current_hour <= 5'd23);

  always_comb begin
    case (r_ptr)
      2'd1:    begin w_o0 = 2'd1; w_o1 = 2'd2; w_o2 = 2'd0; end
      2'd2:    begin w_o0 = 2'd2; w_o1 = 2'd0; w_o2 = 2'd1; end
      default: begin w_o0 = 2'd0; w_o1 = 2'd1; w_o2 = 2'd2; end
    endcase
    if (req[w_o0])      w_sel = w_o0;
    else if (req[w_o1]) w_sel = w_o1;
    else                w_sel = w_o2;
    w_ptr_next = (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
    case (w_sel)
      2'd1:    w_payload = hum_in;
      2'd2:    w_payload = {1'b0, wind_in};
      default: w_payload = temp_in;
    endcase
    w_frame = {^{w_sel, w_payload}, w_sel, w_payload};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_ptr              <= 2'd0;
      r_wait             <= 8'd0;
      r_gap              <= 4'd0;
      grant              <= 3'b000;
      frame              <= 9'd0;
      frame_valid        <= 1'b0;
      enable_transceiver <= 1'b0;
      busy               <= 1'b0;
      drop_cnt           <= 8'd0;
    end else begin
      enable_transceiver <= w_in_window;
      grant              <= 3'b000;
      case (r_state)
        S_IDLE: begin
          if (enable_transceiver && (req != 3'b000)) begin
            grant       <= 3'b001 << w_sel;
            frame       <= w_frame;
            frame_valid <= 1'b1;
            busy        <= 1'b1;
            r_wait      <= 8'd0;
            r_ptr       <= w_ptr_next;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          // A ready on the final wait cycle still counts as a transfer.
          if (frame_ready) begin
            frame_valid <= 1'b0;
            r_gap       <= 4'd0;
            r_state     <= S_GAP;
          end else if (r_wait == L_WAIT_LAST) begin
            frame_valid <= 1'b0;
            r_gap       <= 4'd0;
            r_state     <= S_GAP;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_GAP: begin
          if (r_gap == L_GAP_LAST) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weather_tx_scheduler.sv
// Directed bench for weather_tx_scheduler: expected frames are queued at stimulus time and checked when valid appears.
// A second instance with a short timeout exercises drop counter saturation.
module tb_weather_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] current_hour;
  logic [2:0] req;
  logic [5:0] temp_in;
  logic [5:0] hum_in;
  logic [4:0] wind_in;
  logic       frame_ready;

  logic [2:0] grant;
  logic [8:0] frame;
  logic       frame_valid;
  logic       enable_transceiver;
  logic       busy;
  logic [7:0] drop_cnt;

  logic [2:0] s_grant;
  logic [8:0] s_frame;
  logic       s_frame_valid;
  logic       s_enable;
  logic       s_busy;
  logic [7:0] s_drop_cnt;

  typedef struct packed {
    logic [2:0] g;
    logic [8:0] f;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  weather_tx_scheduler dut (
    .clk(clk), .rst(rst), .current_hour(current_hour), .req(req),
    .temp_in(temp_in), .hum_in(hum_in), .wind_in(wind_in), .frame_ready(frame_ready),
    .grant(grant), .frame(frame), .frame_valid(frame_valid),
    .enable_transceiver(enable_transceiver), .busy(busy), .drop_cnt(drop_cnt)
  );

  weather_tx_scheduler #(.WIN_START(12), .WIN_END(15), .GAP_CYCLES(1), .TIMEOUT(3)) dut_sat (
    .clk(clk), .rst(rst), .current_hour(current_hour), .req(req),
    .temp_in(temp_in), .hum_in(hum_in), .wind_in(wind_in), .frame_ready(frame_ready),
    .grant(s_grant), .frame(s_frame), .frame_valid(s_frame_valid),
    .enable_transceiver(s_enable), .busy(s_busy), .drop_cnt(s_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_frame"}, 32'(frame), 32'h0);
    check({tag, "_valid"}, 32'(frame_valid), 32'h0);
    check({tag, "_en"},    32'(enable_transceiver), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_drop"},  32'(drop_cnt), 32'h0);
  endtask

  // Waits (bounded) for frame_valid, then compares grant/frame with the scoreboard head.
  task automatic expect_frame(input string tag, input int budget, output int waited);
    exp_t e;
    waited = 0;
    while (!frame_valid && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, 32'(frame_valid), 32'h1);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    else e = '{g: 3'b000, f: 9'h1FF};
    check({tag, "_grant"}, 32'(grant), 32'(e.g));
    check({tag, "_frame"}, 32'(frame), 32'(e.f));
    $display("frame %s: grant=%b frame=%h expected grant=%b frame=%h waited=%0d",
             tag, grant, frame, e.g, e.f, waited);
  endtask

  task automatic count_level(input logic lvl, input int budget, output int n);
    n = 0;
    while (frame_valid === lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int   w;
    int   n;
    logic seen;

    rst = 1'b1; current_hour = 5'd0; req = 3'b000;
    temp_in = 6'd43; hum_in = 6'd53; wind_in = 5'd19; frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");

    // Window gating: hour 11 never grants, hour 12 opens after one edge.
    rst = 1'b0; current_hour = 5'd11; req = 3'b001; frame_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | (grant != 3'b000) | enable_transceiver;
    end
    check("gate_h11", 32'(seen), 32'h0);
    current_hour = 5'd12;
    @(negedge clk);
    check("gate_en", 32'(enable_transceiver), 32'h1);
    check("gate_nogrant", 32'(grant), 32'h0);
    sb_q.push_back('{g: 3'b001, f: 9'h02B});
    @(negedge clk);
    expect_frame("gate_temp", 0, w);

    // Temperature frame spacing with the request held.
    current_hour = 5'd13;
    sb_q.push_back('{g: 3'b001, f: 9'h02B});
    count_level(1'b1, 300, n);
    check("temp_high", 32'(n), 32'd1);
    count_level(1'b0, 50, n);
    check("temp_low", 32'(n), 32'd5);
    expect_frame("temp2", 0, w);
    req = 3'b000;
    wait_idle("temp");

    // Humidity then wind (pointer sits at humidity after temperature).
    req = 3'b110;
    sb_q.push_back('{g: 3'b010, f: 9'h175});
    sb_q.push_back('{g: 3'b100, f: 9'h093});
    expect_frame("hum", 10, w);
    req = 3'b100;
    count_level(1'b1, 300, n);
    expect_frame("wind", 20, w);
    req = 3'b000;
    wait_idle("wind");

    // Round-robin from reset.
    rst = 1'b1;
    @(negedge clk);
    check_reset("rr_reset");
    rst = 1'b0; req = 3'b111;
    sb_q.push_back('{g: 3'b001, f: 9'h02B});
    sb_q.push_back('{g: 3'b010, f: 9'h175});
    sb_q.push_back('{g: 3'b100, f: 9'h093});
    expect_frame("rr0", 10, w);
    check("rr0_latency", 32'(w), 32'd2);
    req = 3'b110;
    count_level(1'b1, 300, n);
    expect_frame("rr1", 20, w);
    req = 3'b100;
    count_level(1'b1, 300, n);
    expect_frame("rr2", 20, w);
    req = 3'b000;
    wait_idle("rr2");
    req = 3'b111;
    sb_q.push_back('{g: 3'b001, f: 9'h02B});
    expect_frame("rr3", 10, w);
    req = 3'b000;
    wait_idle("rr3");

    // Timeout with no ready.
    frame_ready = 1'b0; req = 3'b001;
    sb_q.push_back('{g: 3'b001, f: 9'h02B});
    expect_frame("to", 10, w);
    req = 3'b000;
    count_level(1'b1, 400, n);
    check("to_len", 32'(n), 32'd255);
    check("to_drop", 32'(drop_cnt), 32'd1);
    wait_idle("to");

    // Window closes during SEND: frame completes, no new grants.
    current_hour = 5'd15; req = 3'b001;
    sb_q.push_back('{g: 3'b001, f: 9'h02B});
    expect_frame("close", 10, w);
    current_hour = 5'd16;
    repeat (10) @(negedge clk);
    check("close_hold_valid", 32'(frame_valid), 32'h1);
    check("close_hold_frame", 32'(frame), 32'h02B);
    frame_ready = 1'b1;
    @(negedge clk);
    check("close_done", 32'(frame_valid), 32'h0);
    check("close_drop", 32'(drop_cnt), 32'd1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | (grant != 3'b000) | frame_valid;
    end
    check("close_nogrant", 32'(seen), 32'h0);
    check("close_en", 32'(enable_transceiver), 32'h0);

    // Reset in the middle of SEND.
    current_hour = 5'd13; req = 3'b001; frame_ready = 1'b0;
    sb_q.push_back('{g: 3'b001, f: 9'h02B});
    expect_frame("rst_send", 20, w);
    req = 3'b000;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;

    // Long run of timeouts: short-timeout instance saturates, main one counts 5.
    req = 3'b001;
    repeat (1400) @(negedge clk);
    check("sat_drop", 32'(s_drop_cnt), 32'd255);
    check("main_drop_run", 32'(drop_cnt), 32'd5);
    req = 3'b000;

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
